// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// gpio_debounce : two-flop synchroniser, per-bit debounce, edge pulses and a
//                 sticky maskable interrupt-pending register for gpio switches.
// Revision      : 1.0
// ============================================================================
module gpio_debounce #(
  parameter int DATA_WIDTH      = 3,
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   sw_raw,
  input  logic [DATA_WIDTH:0]   irq_mask,
  input  logic [DATA_WIDTH:0]   irq_clear,
  output logic [DATA_WIDTH:0]   sw_clean,
  output logic [DATA_WIDTH:0]   sw_rise,
  output logic [DATA_WIDTH:0]   sw_fall,
  output logic [DATA_WIDTH:0]   irq_pending,
  output logic                  irq
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH:0]  r_sync1;
  logic [DATA_WIDTH:0]  r_sync2;
  logic [CNT_WIDTH-1:0] r_cnt      [DATA_WIDTH+1];
  logic [CNT_WIDTH-1:0] w_cnt_next [DATA_WIDTH+1];
  logic [DATA_WIDTH:0]  w_accept;
  logic [DATA_WIDTH:0]  w_clean_next;
  logic [DATA_WIDTH:0]  w_rise_next;
  logic [DATA_WIDTH:0]  w_fall_next;

  genvar gi;
  generate
    for (gi = 0; gi <= DATA_WIDTH; gi++) begin : g_bit
      // Count only while the synchronised level disagrees with the clean one;
      // agreement or acceptance both return the counter to zero.
      assign w_accept[gi]     = (r_sync2[gi] != sw_clean[gi]) && (r_cnt[gi] == C_CNT_MAX);
      assign w_cnt_next[gi]   = ((r_sync2[gi] == sw_clean[gi]) || w_accept[gi]) ? '0
                                                                                : r_cnt[gi] + C_CNT_ONE;
      assign w_clean_next[gi] = w_accept[gi] ? r_sync2[gi] : sw_clean[gi];
      assign w_rise_next[gi]  = w_accept[gi] &  r_sync2[gi];
      assign w_fall_next[gi]  = w_accept[gi] & ~r_sync2[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      sw_clean    <= '0;
      sw_rise     <= '0;
      sw_fall     <= '0;
      irq_pending <= '0;
      for (int i = 0; i <= DATA_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1     <= sw_raw;
      r_sync2     <= r_sync1;
      sw_clean    <= w_clean_next;
      sw_rise     <= w_rise_next;
      sw_fall     <= w_fall_next;
      // A new masked rising edge wins over a clear in the same cycle.
      irq_pending <= (w_rise_next & irq_mask) | (irq_pending & ~irq_clear);
      for (int i = 0; i <= DATA_WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign irq = |irq_pending;

endmodule
`default_nettype wire

// File: tb/tb_gpio_debounce.sv
`default_nettype none
// Directed table-driven bench for gpio_debounce with DEBOUNCE_CYCLES = 4.
module tb_gpio_debounce;

  localparam int DW = 3;
  localparam int W  = DW + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] irq_mask = '1;
  logic [W-1:0] irq_clear = '0;
  logic [W-1:0] sw_clean, sw_rise, sw_fall, irq_pending;
  logic         irq;

  gpio_debounce #(
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (20),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .irq_mask    (irq_mask),
    .irq_clear   (irq_clear),
    .sw_clean    (sw_clean),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .irq_pending (irq_pending),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] mask;
    logic [W-1:0] clr;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pend;
    logic         irq_e;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic [W-1:0] raw, mask, clr,
                     input logic [W-1:0] clean, rise, fall, pend, input logic irq_e);
    vec_t v;
    v.rst_n = r;  v.raw = raw;   v.mask = mask; v.clr = clr;
    v.clean = clean; v.rise = rise; v.fall = fall; v.pend = pend; v.irq_e = irq_e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic [W-1:0] clean, rise, fall, pend, input logic irq_e);
    chk("sw_clean",    idx, 8'(sw_clean),    8'(clean));
    chk("sw_rise",     idx, 8'(sw_rise),     8'(rise));
    chk("sw_fall",     idx, 8'(sw_fall),     8'(fall));
    chk("irq_pending", idx, 8'(irq_pending), 8'(pend));
    chk("irq",         idx, 8'(irq),         8'(irq_e));
  endtask

  initial begin
    // Reset for three cycles.
    repeat (3) add(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    // Press bit 0: accepted on the 6th edge after the change.
    repeat (5) add(1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h1, 4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1);
    add(1, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
    // Bit 2 glitch: 3 high, 1 low, then held high.
    repeat (3) add(1, 4'h5, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
    add(1, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
    repeat (5) add(1, 4'h5, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
    add(1, 4'h5, 4'hF, 4'h0, 4'h5, 4'h4, 4'h0, 4'h5, 1);
    add(1, 4'h5, 4'hF, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5, 1);
    // Release bit 0: fall pulse, pending untouched.
    repeat (5) add(1, 4'h4, 4'hF, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5, 1);
    add(1, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0, 4'h1, 4'h5, 1);
    add(1, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h5, 1);
    // Clear bit 0, irq stays high from bit 2.
    add(1, 4'h4, 4'hF, 4'h1, 4'h4, 4'h0, 4'h0, 4'h4, 1);
    // Press bit 3 with a clear of bit 3 on the accept edge: set wins.
    repeat (5) add(1, 4'hC, 4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 1);
    add(1, 4'hC, 4'hF, 4'h8, 4'hC, 4'h8, 4'h0, 4'hC, 1);
    // Clear everything: irq low after that edge.
    add(1, 4'hC, 4'hF, 4'hF, 4'hC, 4'h0, 4'h0, 4'h0, 0);
    // Masked press of bit 1: pulse but no pending.
    repeat (5) add(1, 4'hE, 4'h0, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hE, 4'h0, 4'h0, 4'hE, 4'h2, 4'h0, 4'h0, 0);
    add(1, 4'hE, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 0);

    foreach (vecs[k]) begin
      rst       = vecs[k].rst_n;
      sw_raw    = vecs[k].raw;
      irq_mask  = vecs[k].mask;
      irq_clear = vecs[k].clr;
      step();
      chk_all(k, vecs[k].clean, vecs[k].rise, vecs[k].fall, vecs[k].pend, vecs[k].irq_e);
    end

    // Reset mid-count: build pending=0100, start a bit-0 count, reset at cnt=2.
    rst = 0; sw_raw = 4'h0; irq_mask = 4'hF; irq_clear = 4'h0;
    step();
    chk_all(100, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    rst = 1; sw_raw = 4'h4;
    repeat (5) step();
    chk("pre_press_clean", 101, 8'(sw_clean), 8'h0);
    step();
    chk_all(102, 4'h4, 4'h4, 4'h0, 4'h4, 1);
    sw_raw = 4'h5;
    repeat (4) step();
    chk_all(103, 4'h4, 4'h0, 4'h0, 4'h4, 1);
    rst = 0;
    step();
    chk_all(104, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    rst = 1;
    repeat (5) step();
    chk_all(105, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    step();
    chk_all(106, 4'h5, 4'h5, 4'h0, 4'h5, 1);
    step();
    chk_all(107, 4'h5, 4'h0, 4'h0, 4'h5, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
